// File: rtl/cache_line_fill_if.sv
// Bus between the cache access request logic and the line-fill controller.
//   c, v      : access request and hit indication (sampled in IDLE)
//   din       : fill data word
//   rout      : line RAM read data at the current word address
//   counter   : current word index, end_flag high on the last word
//   twr, dwr  : tag write strobe, data RAM write enable
//   rwr, mux  : response-valid strobe and its source (1 = fill, 0 = hit)
//   cnt       : word counter increment enable
interface cache_line_fill_if #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 3
);
  logic              c;
  logic              v;
  logic [DATA_W-1:0] din;
  logic [DATA_W-1:0] rout;
  logic [CNT_W-1:0]  counter;
  logic              end_flag;
  logic              twr;
  logic              dwr;
  logic              rwr;
  logic              cnt;
  logic              mux;

  modport slave (
    input  c, v, din,
    output rout, counter, end_flag, twr, dwr, rwr, cnt, mux
  );

  modport master (
    output c, v, din,
    input  rout, counter, end_flag, twr, dwr, rwr, cnt, mux
  );
endinterface

// File: rtl/cache_line_fill.sv
// Fill controller for one cache line: word counter, control FSM and line RAM.
// On a miss the FSM writes 2^CNT_W incoming words at consecutive counter
// addresses, strobes a tag write, then a response. On a hit it responds at once.
//   clk   : clock, rising edge
//   reset : asynchronous, active-low reset
//   bus   : cache_line_fill_if slave modport (request, data, strobes, status)
module cache_line_fill #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 3,
  parameter int ADDR_W = 11
) (
  input  logic               clk,
  input  logic               reset,
  cache_line_fill_if.slave   bus
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    FILL = 3'd1,
    TAG  = 3'd2,
    DONE = 3'd3,
    HIT  = 3'd4
  } state_t;

  state_t            state, state_nx;
  logic [CNT_W-1:0]  counter;
  logic              end_flag;
  logic              twr, dwr, rwr, cnt, mux;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)   counter <= '0;
    else if (cnt) counter <= counter + 1'b1;
  end

  assign end_flag = (counter == '1);

  always_comb begin
    state_nx = IDLE;
    twr      = 1'b0;
    dwr      = 1'b0;
    rwr      = 1'b0;
    cnt      = 1'b0;
    mux      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.c) state_nx = bus.v ? HIT : FILL;
        else       state_nx = IDLE;
      end
      FILL: begin
        cnt      = 1'b1;
        dwr      = 1'b1;
        // end_flag marks the last word being written this cycle; the counter
        // wraps to 0 on the same edge, so TAG and later fills start at word 0.
        state_nx = end_flag ? TAG : FILL;
      end
      TAG: begin
        twr      = 1'b1;
        state_nx = DONE;
      end
      DONE: begin
        rwr      = 1'b1;
        mux      = 1'b1;
        state_nx = IDLE;
      end
      HIT: begin
        rwr      = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Line RAM: synchronous write, asynchronous read; contents survive reset.
  assign addr = {{(ADDR_W-CNT_W){1'b0}}, counter};

  always_ff @(posedge clk) begin
    if (dwr) mem[addr] <= bus.din;
  end

  assign bus.rout     = mem[addr];
  assign bus.counter  = counter;
  assign bus.end_flag = end_flag;
  assign bus.twr      = twr;
  assign bus.dwr      = dwr;
  assign bus.rwr      = rwr;
  assign bus.cnt      = cnt;
  assign bus.mux      = mux;

endmodule

// File: tb/tb_cache_line_fill.sv
module tb_cache_line_fill;

  logic clk;
  logic reset;

  cache_line_fill_if #(.DATA_W(8), .CNT_W(3)) bus ();

  cache_line_fill #(.DATA_W(8), .CNT_W(3), .ADDR_W(11)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum int { EV_W, EV_T, EV_R } kind_t;
  typedef struct {
    kind_t      kind;
    int         idx;
    logic [7:0] prev;
    bit         chkprev;
    bit         mux;
  } ev_t;

  ev_t        q[$];
  int         checks = 0;
  int         errors = 0;
  bit         done   = 0;
  logic [7:0] model [8];
  bit         mval  [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: whenever the DUT raises a strobe, pop the next expected event.
  always @(negedge clk) begin
    ev_t e;
    if (!done && reset === 1'b1 && (bus.dwr || bus.twr || bus.rwr)) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe: got dwr=%b twr=%b rwr=%b expected none at %0t",
                 bus.dwr, bus.twr, bus.rwr, $time);
      end else begin
        e = q.pop_front();
        case (e.kind)
          EV_W: begin
            chk("fill_strobes", {28'd0, bus.dwr, bus.cnt, bus.twr, bus.rwr}, 32'b1100);
            chk("fill_counter", {29'd0, bus.counter}, e.idx);
            chk("fill_end_flag", {31'd0, bus.end_flag}, (e.idx == 7) ? 1 : 0);
            if (e.chkprev) chk("readback", {24'd0, bus.rout}, {24'd0, e.prev});
          end
          EV_T: begin
            chk("tag_strobes", {28'd0, bus.dwr, bus.cnt, bus.twr, bus.rwr}, 32'b0010);
            chk("tag_counter", {29'd0, bus.counter}, 0);
          end
          default: begin
            chk("resp_strobes", {28'd0, bus.dwr, bus.cnt, bus.twr, bus.rwr}, 32'b0001);
            chk("resp_mux", {31'd0, bus.mux}, {31'd0, e.mux});
            chk("resp_counter", {29'd0, bus.counter}, 0);
          end
        endcase
      end
    end
  end

  task automatic push(input kind_t k, input int idx, input bit m);
    ev_t e;
    e.kind = k; e.idx = idx; e.mux = m; e.chkprev = 0; e.prev = '0;
    if (k == EV_W) begin
      e.prev    = model[idx];
      e.chkprev = mval[idx];
    end
    q.push_back(e);
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_ctrl"}, {27'd0, bus.twr, bus.dwr, bus.rwr, bus.cnt, bus.mux}, 0);
    chk({tag, "_counter"}, {29'd0, bus.counter}, 0);
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while (q.size() != 0 && n < 40) begin
      @(posedge clk);
      n++;
    end
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: got %0d pending events expected 0", tag, q.size());
      q.delete();
    end
  endtask

  // Issue a miss and supply nwords data words; full fills also expect TAG and DONE.
  task automatic miss(input logic [7:0] base, input int nwords);
    @(posedge clk); #1;
    bus.c = 1'b1; bus.v = 1'b0;
    for (int i = 0; i < nwords; i++) begin
      push(EV_W, i, 1'b0);
      model[i] = base + 8'(i);
      mval[i]  = 1'b1;
    end
    if (nwords == 8) begin
      push(EV_T, 0, 1'b0);
      push(EV_R, 0, 1'b1);
    end
    @(posedge clk); #1;
    bus.c = 1'b0;
    for (int i = 0; i < nwords; i++) begin
      bus.din = base + 8'(i);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 8; i++) begin model[i] = '0; mval[i] = 0; end
    reset = 1'b0; bus.c = 1'b0; bus.v = 1'b0; bus.din = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check_idle("reset");
    chk("reset_end_flag", {31'd0, bus.end_flag}, 0);
    repeat (10) @(posedge clk);
    #1 check_idle("idle_hold");

    // Hit: one sampled request with v=1.
    @(posedge clk); #1;
    bus.c = 1'b1; bus.v = 1'b1;
    push(EV_R, 0, 1'b0);
    @(posedge clk); #1;
    bus.c = 1'b0; bus.v = 1'b0;
    wait_drain("hit");
    @(posedge clk); #1 check_idle("after_hit");

    // Miss fills: first writes 0x10.., second reads them back and overwrites.
    miss(8'h10, 8);
    wait_drain("miss1");
    @(posedge clk); #1 check_idle("after_miss1");
    miss(8'h20, 8);
    wait_drain("miss2");
    @(posedge clk); #1 check_idle("after_miss2");

    // Reset after word 3 has been written.
    miss(8'h30, 4);
    reset = 1'b0;
    #1 check_idle("abort");
    chk("abort_queue", q.size(), 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    repeat (15) @(posedge clk);
    #1 check_idle("after_abort");

    // Words 0..3 hold 0x30.., words 4..7 still 0x24..0x27.
    miss(8'h40, 8);
    wait_drain("miss3");
    @(posedge clk); #1 check_idle("after_miss3");

    // Request held through HIT: re-sampled every other cycle.
    @(posedge clk); #1;
    bus.c = 1'b1; bus.v = 1'b1;
    push(EV_R, 0, 1'b0);
    push(EV_R, 0, 1'b0);
    push(EV_R, 0, 1'b0);
    repeat (5) @(posedge clk);
    #1 bus.c = 1'b0; bus.v = 1'b0;
    wait_drain("held");
    repeat (5) @(posedge clk);
    #1 check_idle("final");

    done = 1'b1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cache_line_fill.md
Name: cache_line_fill

Overview:
- Controls the fill of one 8-word cache line. An FSM steps a 3-bit word counter and writes incoming data words into a line RAM at the counter's address.
- After the last word it strobes a tag write, then a response.
- On a hit the FSM gives the response immediately, with no fill.
- The block sits between the cache access request logic and the data array. It combines the word counter, the control FSM and the line RAM in one module.

Parameters:
- DATA_W, 8, data word width.
- CNT_W, 3, word counter width; a line holds 2^CNT_W = 8 words.
- ADDR_W, 11, RAM address width. The RAM address is {(ADDR_W-CNT_W) zero bits, counter}. RAM depth is 2^ADDR_W.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- c  in  1  cache access request; sampled only in IDLE.
- v  in  1  hit indication (line valid and tag match); sampled with c in IDLE.
- din  in  DATA_W  fill data word, written during FILL.
- rout  out  DATA_W  RAM read data at the current RAM address (combinational read).
- counter  out  CNT_W  current word index.
- end_flag  out  1  high while counter == 2^CNT_W-1.
- twr  out  1  tag write strobe.
- dwr  out  1  data RAM write enable.
- rwr  out  1  response-valid strobe.
- cnt  out  1  counter increment enable.
- mux  out  1  response source: 1 = fill completion, 0 = hit.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE and counter to 0.
  - All control outputs (twr, dwr, rwr, cnt, mux) are 0.
  - end_flag is 0.
  - RAM contents are not cleared.
- Counter:
  - On each rising edge with cnt=1, counter increments by 1.
  - It wraps from 7 to 0; there is no saturation.
  - end_flag is combinational: end_flag = (counter == 7).
- RAM:
  - Write is synchronous: on a rising edge with dwr=1, mem[{0,counter}] <= din.
  - Read is asynchronous: rout = mem[{0,counter}].
  - A write becomes visible on rout after the clock edge.
  - Words that have never been written read as X.
- FSM states and outputs (Moore outputs; anything not listed is 0):
  - IDLE: all outputs 0.
    - c=1 and v=1 -> HIT.
    - c=1 and v=0 -> FILL.
    - c=0 -> stay in IDLE.
  - FILL: cnt=1, dwr=1.
    - Writes din into word [counter] each cycle.
    - If end_flag=1 (word 7 is being written this cycle) -> TAG; otherwise stay in FILL.
    - c and v are ignored.
  - TAG: twr=1, for one cycle; counter is already back at 0 after the wrap. -> DONE.
  - DONE: rwr=1, mux=1, for one cycle. -> IDLE.
  - HIT: rwr=1, mux=0, for one cycle. -> IDLE.
- Latency:
  - Miss: the request is sampled at edge k. Words 0..7 are written at edges k+1..k+8. TAG is the cycle after edge k+8, DONE the cycle after edge k+9, and the FSM is back in IDLE after edge k+10.
  - Hit: rwr is high in the cycle after the sampling edge.
- Boundaries:
  - Counter enters a fill at 0 and leaves it at 0, so back-to-back fills start at word 0.
  - A request held high through DONE or HIT is re-sampled in IDLE and starts a new transaction.
  - Reset during FILL aborts the fill: IDLE, counter 0. Words already written remain in the RAM, and no twr or rwr is issued.
  - Unused state encodings recover to IDLE.

Test Plan:
- Reset: hold reset=0 for 2 cycles, then release -> counter=0, end_flag=0, and twr, dwr, rwr, cnt, mux all 0. With c=0 the FSM stays idle indefinitely.
- Hit: v=1, then c=1 for one sampled edge -> rwr=1, mux=0 for exactly 1 cycle; dwr and cnt never assert; counter stays 0.
- Miss fill: v=0, c=1 pulse, din = 8'h10 + word index each cycle -> dwr and cnt high for 8 cycles, end_flag high in the 8th. Then twr=1 for 1 cycle, then rwr=1 with mux=1 for 1 cycle, then idle. Stepping counter 0..7 afterwards (via a second fill, with din monitored) reads back 8'h10..8'h17 on rout.
- Wrap: after a complete fill, counter=0. A second miss writes starting again at word 0 and overwrites those contents.
- Reset mid-fill: assert reset after word 3 is written -> outputs drop to 0 immediately (asynchronously) and counter=0. After release, no twr or rwr occurs until a new request.
- Request held high: c=1, v=1 held for 5 cycles -> rwr pulses every other cycle (IDLE/HIT alternation).
